// File: rtl/meter_reading_tx_if.sv
// rtl/meter_reading_tx_if.sv - meter pulse input, billing request and byte stream bundle
interface meter_reading_tx_if;
  logic        pulse_in;
  logic        req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [12:0] units;

  modport master (
    input  pulse_in,
    input  req,
    input  tx_ready,
    output tx_data,
    output tx_valid,
    output busy,
    output units
  );

  modport slave (
    output pulse_in,
    output req,
    output tx_ready,
    input  tx_data,
    input  tx_valid,
    input  busy,
    input  units
  );
endinterface

// File: rtl/meter_reading_tx.sv
// rtl/meter_reading_tx.sv - energy pulse to unit counter with framed meter reading transmitter
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte (6-byte frame instead of 5).
module meter_reading_tx #(
  parameter logic [11:0] METER_ID        = 12'd1000,
  parameter int          PULSES_PER_UNIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  meter_reading_tx_if.master bus
);

  localparam logic [7:0] HEADER     = 8'hA5;
  localparam logic [7:0] LAST_PULSE = 8'(PULSES_PER_UNIT - 1);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX   = 3'd5;
`else
  localparam logic [2:0] LAST_IDX   = 3'd4;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, stateNext;
  logic [2:0]  byteIdx, byteIdxNext;
  logic [12:0] snapshot, snapshotNext;
  logic [7:0]  txData, txDataNext;
  logic        txValid, txValidNext;
  logic        busy, busyNext;

  logic        pulsePrev;
  logic [7:0]  pulseCnt;
  logic [12:0] units;
  logic        pulseEdge;
  logic        transfer;

  function automatic logic [7:0] frameByte(input logic [2:0] idx, input logic [12:0] snap);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = {4'h0, METER_ID[11:8]};
      3'd2:    b = METER_ID[7:0];
      3'd3:    b = {3'b000, snap[12:8]};
      3'd4:    b = snap[7:0];
`ifdef FRAME_CHECKSUM_EN
      3'd5:    b = {4'h0, METER_ID[11:8]} ^ METER_ID[7:0] ^ {3'b000, snap[12:8]} ^ snap[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign pulseEdge = bus.pulse_in & ~pulsePrev;
  assign transfer  = txValid & bus.tx_ready;

  // Pulse counting runs regardless of the transmitter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulsePrev <= 1'b0;
      pulseCnt  <= 8'd0;
      units     <= 13'd0;
    end else begin
      pulsePrev <= bus.pulse_in;
      if (pulseEdge) begin
        if (pulseCnt == LAST_PULSE) begin
          pulseCnt <= 8'd0;
          units    <= units + 13'd1;
        end else begin
          pulseCnt <= pulseCnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byteIdx  <= 3'd0;
      snapshot <= 13'd0;
      txData   <= 8'h00;
      txValid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      byteIdx  <= byteIdxNext;
      snapshot <= snapshotNext;
      txData   <= txDataNext;
      txValid  <= txValidNext;
      busy     <= busyNext;
    end
  end

  // Snapshot takes the registered units value, so a unit completing in the
  // request cycle shows up only in the next reading.
  always_comb begin
    stateNext    = state;
    byteIdxNext  = byteIdx;
    snapshotNext = snapshot;
    txDataNext   = txData;
    txValidNext  = txValid;
    busyNext     = busy;
    case (state)
      IDLE: begin
        if (bus.req) begin
          stateNext    = SEND;
          byteIdxNext  = 3'd0;
          snapshotNext = units;
          txDataNext   = HEADER;
          txValidNext  = 1'b1;
          busyNext     = 1'b1;
        end
      end
      SEND: begin
        if (transfer) begin
          if (byteIdx == LAST_IDX) begin
            stateNext   = IDLE;
            byteIdxNext = 3'd0;
            txDataNext  = 8'h00;
            txValidNext = 1'b0;
            busyNext    = 1'b0;
          end else begin
            byteIdxNext = byteIdx + 3'd1;
            txDataNext  = frameByte(byteIdx + 3'd1, snapshot);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.tx_data  = txData;
  assign bus.tx_valid = txValid;
  assign bus.busy     = busy;
  assign bus.units    = units;

endmodule
